// File: rtl/lab2_proc_mem_responder_pkg.sv
// Memory message types and type constants shared by the responder, its queue and the bench.
// The request is 77 bits and the response is 47 bits, most-significant field first.
package lab2_proc_mem_responder_pkg;

  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_WRITE = 3'd1;
  localparam logic [2:0] VC_MEM_REQ_MSG_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4b_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4b_t;

  localparam int MEM_RESP_NBITS = $bits(mem_resp_4b_t);

  // INIT behaves exactly like WRITE; every unknown type behaves like READ.
  function automatic logic is_write_type(input logic [2:0] t);
    return (t == VC_MEM_REQ_MSG_TYPE_WRITE) || (t == VC_MEM_REQ_MSG_TYPE_INIT);
  endfunction

endpackage

// File: rtl/lab2_proc_mem_responder_queue.sv
// In-order circular response buffer without bypass paths.
// The instantiating logic guarantees it never enqueues while full.
module lab2_proc_mem_responder_queue
  import lab2_proc_mem_responder_pkg::*;
#(
  parameter int p_msg_nbits   = MEM_RESP_NBITS,
  parameter int p_num_entries = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg
);

  localparam int AW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = $clog2(p_num_entries + 1);

  logic [p_msg_nbits-1:0] entries [0:p_num_entries-1];
  logic [AW-1:0]          enq_ptr_reg;
  logic [AW-1:0]          deq_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic                   deq_fire;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(p_num_entries - 1)) ? '0 : p + AW'(1);
  endfunction

  assign deq_val  = (count_reg != '0);
  assign deq_msg  = entries[deq_ptr_reg];
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (enq_val) begin
      entries[enq_ptr_reg] <= enq_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_reg <= '0;
      deq_ptr_reg <= '0;
      count_reg   <= '0;
    end else begin
      if (enq_val)  enq_ptr_reg <= ptr_inc(enq_ptr_reg);
      if (deq_fire) deq_ptr_reg <= ptr_inc(deq_ptr_reg);
      case ({enq_val, deq_fire})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/lab2_proc_mem_responder.sv
// Pipelined single-port word memory answering val/rdy requests after a fixed latency,
// with a credit counter and response queue giving full backpressure.
module lab2_proc_mem_responder
  import lab2_proc_mem_responder_pkg::*;
#(
  parameter int p_mem_nwords  = 256,
  parameter int p_latency     = 2,
  parameter int p_num_entries = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4b_t  memreq_msg,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  output mem_resp_4b_t memresp_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy
);

  localparam int AW = $clog2(p_mem_nwords);
  localparam int CW = $clog2(p_num_entries + 1);

  logic [31:0]   mem_array [0:p_mem_nwords-1];
  logic [CW-1:0] cnt_reg;

  logic          req_fire;
  logic          resp_fire;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic [2:0]    nbytes;
  logic          wr_en;
  logic [3:0]    wr_mask;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  mem_resp_4b_t  resp_next;
  logic          enq_val;
  mem_resp_4b_t  enq_msg;
  logic          unused_addr_bits;

  // Right-justify the accessed bytes; anything past byte 3 is clipped.
  function automatic logic [31:0] extract_bytes(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  n);
    logic [31:0] shifted;
    logic [2:0]  avail;
    logic [2:0]  keep;
    shifted = word >> {off, 3'b000};
    avail   = 3'd4 - {1'b0, off};
    keep    = (n < avail) ? n : avail;
    extract_bytes = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < keep) extract_bytes[8*b +: 8] = shifted[8*b +: 8];
    end
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] n);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = {2'b00, off};
    hi = lo + {1'b0, n};
    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[b] = (4'(b) >= lo) && (4'(b) < hi);
    end
  endfunction

  assign memreq_rdy = !reset && (cnt_reg < CW'(p_num_entries));
  assign req_fire   = memreq_val && memreq_rdy;
  assign resp_fire  = memresp_val && memresp_rdy;

  assign word_idx = memreq_msg.addr[AW+1:2];
  assign byte_off = memreq_msg.addr[1:0];
  assign nbytes   = (memreq_msg.len == 2'd0) ? 3'd4 : {1'b0, memreq_msg.len};
  assign wr_en    = req_fire && is_write_type(memreq_msg.type_);
  assign wr_mask  = lane_mask(byte_off, nbytes);
  assign wr_data  = memreq_msg.data << {byte_off, 3'b000};
  assign rd_word  = mem_array[word_idx];

  assign unused_addr_bits = ^memreq_msg.addr[31:AW+2];

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem_array[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_next        = '0;
    resp_next.type_  = memreq_msg.type_;
    resp_next.opaque = memreq_msg.opaque;
    resp_next.test   = 2'd0;
    resp_next.len    = memreq_msg.len;
    resp_next.data   = is_write_type(memreq_msg.type_) ? 32'd0
                                                       : extract_bytes(rd_word, byte_off, nbytes);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (req_fire && !resp_fire) begin
      cnt_reg <= cnt_reg + CW'(1);
    end else if (!req_fire && resp_fire) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  // The queue's own storage provides the last cycle of delay, so only
  // p_latency-1 registered stages sit between the fire and the enqueue.
  generate
    if (p_latency == 1) begin : g_direct
      assign enq_val = req_fire;
      assign enq_msg = resp_next;
    end else begin : g_delay
      logic [p_latency-2:0] dl_val_reg;
      mem_resp_4b_t         dl_msg_reg [0:p_latency-2];

      always_ff @(posedge clk) begin
        if (reset) begin
          dl_val_reg <= '0;
        end else begin
          dl_val_reg[0] <= req_fire;
          for (int i = 1; i < p_latency - 1; i++) dl_val_reg[i] <= dl_val_reg[i-1];
        end
        dl_msg_reg[0] <= resp_next;
        for (int i = 1; i < p_latency - 1; i++) dl_msg_reg[i] <= dl_msg_reg[i-1];
      end

      assign enq_val = dl_val_reg[p_latency-2];
      assign enq_msg = dl_msg_reg[p_latency-2];
    end
  endgenerate

  lab2_proc_mem_responder_queue #(
    .p_msg_nbits   (MEM_RESP_NBITS),
    .p_num_entries (p_num_entries)
  ) resp_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (enq_val),
    .enq_msg (enq_msg),
    .deq_val (memresp_val),
    .deq_rdy (memresp_rdy),
    .deq_msg (memresp_msg)
  );

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
// Bench for lab2_proc_mem_responder: byte-level memory model with an expected-response
// queue checked every cycle, a directed vector table and multi-cycle corner sequences.
module tb_lab2_proc_mem_responder;
  import lab2_proc_mem_responder_pkg::*;

  localparam int NW = 256;
  localparam int L  = 2;
  localparam int N  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  mem_req_4b_t  memreq_msg = '0;
  logic         memreq_val = 1'b0;
  logic         memreq_rdy;
  mem_resp_4b_t memresp_msg;
  logic         memresp_val;
  logic         memresp_rdy = 1'b1;

  lab2_proc_mem_responder #(
    .p_mem_nwords (NW),
    .p_latency    (L),
    .p_num_entries(N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .memreq_msg (memreq_msg),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memresp_msg(memresp_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model: byte memory + expected response queue
  typedef struct { mem_resp_4b_t msg; int fire_cycle; } exp_t;
  typedef struct { mem_resp_4b_t msg; int cycle; int latency; } log_t;

  logic [7:0] mmem [0:NW*4-1];
  exp_t       exp_q[$];
  log_t       resp_log[$];

  function automatic mem_resp_4b_t model_access(input mem_req_4b_t r);
    int n;
    int off;
    logic [31:0] rd;
    logic wr;
    mem_resp_4b_t o;
    n   = (r.len == 2'd0) ? 4 : int'(r.len);
    off = int'(r.addr[1:0]);
    wr  = (r.type_ == 3'd1) || (r.type_ == 3'd2);
    rd  = '0;
    for (int k = 0; k < n && off + k < 4; k++) begin
      int a;
      a = int'(r.addr[9:2]) * 4 + off + k;
      if (wr) mmem[a] = r.data[8*k +: 8];
      else    rd[8*k +: 8] = mmem[a];
    end
    o.type_  = r.type_;
    o.opaque = r.opaque;
    o.test   = 2'd0;
    o.len    = r.len;
    o.data   = wr ? 32'd0 : rd;
    return o;
  endfunction

  always @(negedge clk) begin
    bit   ev;
    log_t e;
    exp_t x;
    if (reset) begin
      exp_q.delete();
      check("rdy_in_reset", 64'(memreq_rdy), 64'(0));
    end else begin
      ev = (exp_q.size() > 0) && (cycle >= exp_q[0].fire_cycle + L);
      check("resp_val", 64'(memresp_val), 64'(ev));
      check("req_rdy", 64'(memreq_rdy), 64'(exp_q.size() < N));
      if (memresp_val && ev) check("resp_msg", 64'(memresp_msg), 64'(exp_q[0].msg));
      if (memresp_val && memresp_rdy) begin
        e.msg = memresp_msg;
        e.cycle = cycle;
        e.latency = -1;
        if (exp_q.size() > 0) begin
          e.latency = cycle - exp_q[0].fire_cycle;
          void'(exp_q.pop_front());
        end
        resp_log.push_back(e);
      end
      if (memreq_val && memreq_rdy) begin
        x.msg = model_access(memreq_msg);
        x.fire_cycle = cycle;
        exp_q.push_back(x);
      end
    end
  end

  // ---------------- stimulus helpers (inputs change at posedge + 1)
  function automatic mem_req_4b_t mk(input logic [2:0] t, input logic [31:0] a,
                                     input logic [1:0] len, input logic [31:0] d,
                                     input logic [7:0] op);
    mem_req_4b_t m;
    m.type_ = t; m.opaque = op; m.addr = a; m.len = len; m.data = d;
    return m;
  endfunction

  task automatic send(input mem_req_4b_t m);
    bit ok;
    ok = 0;
    memreq_msg = m;
    memreq_val = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = memreq_rdy;
      @(posedge clk); #1;
    end
    memreq_val = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'(1));
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  typedef struct {
    logic [2:0]  type_;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic [7:0]  opaque;
    logic [31:0] exp_data;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int n0;
    log_t e;
    n0 = resp_log.size();
    send(mk(v.type_, v.addr, v.len, v.data, v.opaque));
    for (int i = 0; i < 20 && resp_log.size() == n0; i++) @(negedge clk);
    @(posedge clk); #1;
    check($sformatf("vec%0d_got_resp", id), 64'(resp_log.size()), 64'(n0 + 1));
    if (resp_log.size() > n0) begin
      e = resp_log[n0];
      $display("vec %0d: type %0d addr %h len %0d -> data %h opaque %h latency %0d",
               id, v.type_, v.addr, v.len, e.msg.data, e.msg.opaque, e.latency);
      check($sformatf("vec%0d_data", id), 64'(e.msg.data), 64'(v.exp_data));
      check($sformatf("vec%0d_type", id), 64'(e.msg.type_), 64'(v.type_));
      check($sformatf("vec%0d_opaque", id), 64'(e.msg.opaque), 64'(v.opaque));
      check($sformatf("vec%0d_test", id), 64'(e.msg.test), 64'(0));
      check($sformatf("vec%0d_latency", id), 64'(e.latency), 64'(L));
    end
  endtask

  vec_t vecs [16];

  initial begin
    int n0;
    int accepted;
    log_t a;
    log_t b;

    vecs[0]  = '{3'd1, 32'h10,  2'd0, 32'hdeadbeef, 8'h03, 32'h0};
    vecs[1]  = '{3'd0, 32'h10,  2'd0, 32'h0,        8'h04, 32'hdeadbeef};
    vecs[2]  = '{3'd1, 32'h20,  2'd0, 32'h11223344, 8'h05, 32'h0};
    vecs[3]  = '{3'd1, 32'h21,  2'd1, 32'h000000aa, 8'h06, 32'h0};
    vecs[4]  = '{3'd0, 32'h20,  2'd0, 32'h0,        8'h07, 32'h1122aa44};
    vecs[5]  = '{3'd0, 32'h22,  2'd2, 32'h0,        8'h08, 32'h00001122};
    vecs[6]  = '{3'd0, 32'h23,  2'd2, 32'h0,        8'h09, 32'h00000011};
    vecs[7]  = '{3'd1, 32'h400, 2'd0, 32'h5,        8'h0a, 32'h0};
    vecs[8]  = '{3'd0, 32'h0,   2'd0, 32'h0,        8'h0b, 32'h5};
    vecs[9]  = '{3'd1, 32'h30,  2'd0, 32'h01020304, 8'h0c, 32'h0};
    vecs[10] = '{3'd2, 32'h31,  2'd3, 32'hffabcdef, 8'h0d, 32'h0};
    vecs[11] = '{3'd0, 32'h30,  2'd0, 32'h0,        8'h0e, 32'habcdef04};
    vecs[12] = '{3'd3, 32'h30,  2'd1, 32'h0,        8'h0f, 32'h04};
    vecs[13] = '{3'd0, 32'h32,  2'd3, 32'h0,        8'h10, 32'h0000abcd};
    vecs[14] = '{3'd7, 32'h10,  2'd0, 32'h12345678, 8'h11, 32'hdeadbeef};
    vecs[15] = '{3'd0, 32'h10,  2'd0, 32'h0,        8'h12, 32'hdeadbeef};

    // reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rdy", 64'(memreq_rdy), 64'(1));
    check("reset_resp_val", 64'(memresp_val), 64'(0));
    @(posedge clk); #1;

    // initialise every word, back to back
    for (int i = 0; i < NW; i++) send(mk(3'd2, 32'(i * 4), 2'd0, $urandom, 8'(i)));
    drain(40);
    $display("init: %0d words written", NW);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // write then read same word on consecutive cycles
    send(mk(3'd1, 32'h40, 2'd0, 32'hcafef00d, 8'h20));
    send(mk(3'd0, 32'h40, 2'd0, 32'h0, 8'h21));
    drain(20);
    a = resp_log[resp_log.size()-2];
    b = resp_log[resp_log.size()-1];
    $display("wr->rd: data %h at cycles %0d,%0d", b.msg.data, a.cycle, b.cycle);
    check("wr_rd_data", 64'(b.msg.data), 64'(32'hcafef00d));
    check("wr_rd_consecutive", 64'(b.cycle - a.cycle), 64'(1));

    // 16 back-to-back reads
    n0 = resp_log.size();
    memreq_val = 1'b1;
    for (int i = 0; i < 16; i++) begin
      memreq_msg = mk(3'd0, 32'(i * 4), 2'd0, 32'h0, 8'(i));
      @(negedge clk);
      check("b2b_rdy", 64'(memreq_rdy), 64'(1));
      @(posedge clk); #1;
    end
    memreq_val = 1'b0;
    drain(20);
    check("b2b_count", 64'(resp_log.size() - n0), 64'(16));
    for (int i = 0; i < 16 && n0 + i < resp_log.size(); i++) begin
      check("b2b_opaque", 64'(resp_log[n0+i].msg.opaque), 64'(i));
      check("b2b_cycle", 64'(resp_log[n0+i].cycle - resp_log[n0].cycle), 64'(i));
    end
    $display("b2b: %0d responses", resp_log.size() - n0);

    // backpressure
    memresp_rdy = 1'b0;
    accepted = 0;
    memreq_val = 1'b1;
    for (int i = 0; i < 20; i++) begin
      memreq_msg = mk(3'd0, 32'(i * 4), 2'd0, 32'h0, 8'(8'h40 + i));
      @(negedge clk);
      if (!memreq_rdy) break;
      accepted++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    memreq_val = 1'b0;
    $display("backpressure: %0d accepted", accepted);
    check("bp_accepted", 64'(accepted), 64'(N));
    repeat (3) begin @(posedge clk); #1; end
    n0 = resp_log.size();
    memresp_rdy = 1'b1;
    @(negedge clk);
    check("bp_first_resp_val", 64'(memresp_val), 64'(1));
    check("bp_rdy_same_cycle", 64'(memreq_rdy), 64'(0));
    @(negedge clk);
    check("bp_rdy_next_cycle", 64'(memreq_rdy), 64'(1));
    @(posedge clk); #1;
    drain(20);
    check("bp_drained", 64'(resp_log.size() - n0), 64'(N));
    for (int i = 0; i < N && n0 + i < resp_log.size(); i++)
      check("bp_order", 64'(resp_log[n0+i].msg.opaque), 64'(8'h40 + i));

    // reset with three reads in flight
    memresp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(3'd0, 32'h10, 2'd0, 32'h0, 8'(8'h60 + i)));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n0 = resp_log.size();
    memresp_rdy = 1'b1;
    @(negedge clk);
    check("rst_mid_rdy", 64'(memreq_rdy), 64'(1));
    check("rst_mid_val", 64'(memresp_val), 64'(0));
    repeat (8) @(negedge clk);
    check("rst_mid_no_resp", 64'(resp_log.size()), 64'(n0));
    $display("reset mid-flight: %0d stray responses", resp_log.size() - n0);
    @(posedge clk); #1;
    run_vec(vecs[15], 99);

    // random traffic with random output stalls
    for (int i = 0; i < 500; i++) begin
      memreq_val  = ($urandom_range(3) != 0);
      memreq_msg  = mk(3'($urandom_range(3)), $urandom, 2'($urandom_range(3)), $urandom,
                       8'($urandom_range(255)));
      memresp_rdy = ($urandom_range(2) != 0);
      @(posedge clk); #1;
    end
    memreq_val  = 1'b0;
    memresp_rdy = 1'b1;
    drain(40);
    $display("random: %0d total responses logged", resp_log.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lab2_proc_mem_responder.md
# lab2_proc_mem_responder

Pipelined single-port memory responder: the target end of the `mem_req_4B_t`/`mem_resp_4B_t` val/rdy protocol that the pipelined processor issues on its imem and dmem ports. It accepts one request per cycle into a word array and returns each response a fixed `p_latency` cycles later. A bounded response buffer and credit counter provide full backpressure. Two instances (imem, dmem) form the processor's test-harness memory system.

## Interface
- `p_mem_nwords`, 256: array depth in 32-bit words; power of two ≥ 4.
- `p_latency`, 2: cycles from request acceptance to earliest response-valid; ≥ 1.
- `p_num_entries`, 4: maximum outstanding requests (accepted, response not yet consumed); ≥ `p_latency`.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `memreq_msg` in 77: `mem_req_4B_t` {type_, opaque, addr, len, data}.
- `memreq_val` in 1: request valid.
- `memreq_rdy` out 1: request ready.
- `memresp_msg` out 47: `mem_resp_4B_t` {type_, opaque, test, len, data}.
- `memresp_val` out 1: response valid.
- `memresp_rdy` in 1: response ready.

## Operation
- Request fires when `memreq_val && memreq_rdy`; response fires when `memresp_val && memresp_rdy`.
- Word index = `addr[$clog2(p_mem_nwords)+1:2]`; higher address bits ignored, so addresses wrap modulo array size.
- Byte count n = 4 if `len`==0, else `len`. Accessed bytes: offsets `addr[1:0]` .. `addr[1:0]+n-1`, clipped at byte 3; bytes past the word boundary are dropped.
- WRITE (type 1) and INIT (type 2): write `data[8n-1:0]` into the accessed bytes at the fire edge. Response data = 0.
- READ (type 0) and every other type: no array change. Response data = accessed bytes right-justified, upper bits zero.
- Response `type_`, `opaque`, `len` echo the request; `test` = 0.
- Array read occurs in the fire cycle, after all earlier-accepted writes. A read accepted the cycle after a write to the same word returns the new data. A request's own write is not visible to itself.
- Requests are serviced strictly in order; responses are never reordered or dropped.
- Outstanding count `cnt`, width `$clog2(p_num_entries+1)`:
  - +1 on request fire; −1 on response fire; unchanged when both occur.
  - `memreq_rdy = !reset && (cnt < p_num_entries)`. A response firing in the same cycle does not free a slot until the next cycle.
- Delay line: `p_latency`-stage shift register of {val, resp msg}. The stage-0 input is the fire result. Stages shift every cycle unconditionally.
- The final stage enqueues into a response queue of depth `p_num_entries`. The credit counter guarantees the enqueue never overflows the queue.
- Array contents are not cleared by reset.

## Timing
- Reset values: `memreq_rdy`=0 while `reset` is high, 1 in the first cycle after. `memresp_val`=0. `cnt`=0. Delay-line valids and response queue are cleared.
- Reset asserted mid-operation discards every in-flight and queued response. Array writes already performed persist.
- With `memresp_rdy` held high, a request fired in cycle t has `memresp_val`=1 in cycle t+`p_latency` and completes then. Sustained throughput: 1 request/cycle once `p_num_entries` ≥ `p_latency`+1.
- Output stall: responses accumulate in the queue. After `p_num_entries` outstanding, `memreq_rdy` drops. It rises the cycle after the first response fire.
- `memresp_msg` is held stable while `memresp_val && !memresp_rdy`.
- `memreq_rdy` does not depend combinationally on `memreq_val` or `memresp_rdy`.

## Structure
- Message typedefs and type constants (`VC_MEM_REQ_MSG_TYPE_*`) come from the shared `vc/mem-msgs.v` package; nothing new is added there.
- Byte-lane mask/shift logic is a local function.
- One sub-module: `vc_Queue` (`VC_QUEUE_NORMAL`, 47 bits, `p_num_entries`) as the response buffer. The delay line and counter are inline.
- A line-trace block prints fired requests/responses using `vc_MemReqMsg4BTrace`/`vc_MemRespMsg4BTrace`.

## Test plan
- Write-then-read: WRITE addr 0x10 data 0xdeadbeef len 0 opaque 0x3, then READ 0x10 opaque 0x4. Required: responses {type 1, opaque 0x3, data 0} and {type 0, opaque 0x4, data 0xdeadbeef}, each exactly `p_latency` cycles after its fire.
- Subword: WRITE 0x20 len 0 data 0x11223344, WRITE 0x21 len 1 data 0xaa, READ 0x20 len 0 -> 0x1122aa44. READ 0x22 len 2 -> 0x00001122. READ 0x23 len 2 -> 0x00000011 (clipped).
- Back-to-back: 16 reads with `memresp_rdy`=1. Required: `memreq_rdy` constantly 1, 16 consecutive response cycles, opaques in order 0..15.
- Backpressure: `memresp_rdy`=0, issue requests until `memreq_rdy`=0. Required: exactly `p_num_entries` accepted. Raise `memresp_rdy`: `memreq_rdy` returns 1 one cycle after the first response fire, and all responses drain in order.
- Wrap: with `p_mem_nwords`=256, WRITE 0x400 data 0x5, then READ 0x0 -> 0x5.
- Reset mid-flight: 3 reads outstanding, pulse `reset` one cycle. Required: no responses ever appear for them, `cnt`=0, `memreq_rdy`=1 the next cycle, and prior writes are still readable.
